// File: rtl/fifo_uart9_pkg.sv
// rtl/fifo_uart9_pkg.sv - shared state codes and frame constants for the 9-bit UART drain stage
package fifo_uart9_pkg;

  localparam int FrameDataBits = 9;
  localparam logic [3:0] LastBitIdx = 4'd8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_START = 3'd2;
  localparam state_t S_DATA  = 3'd3;
  localparam state_t S_STOP  = 3'd4;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter; tick marks the last cycle of each serial bit
module uart_bit_timer #(
  parameter int ClkDiv = 16
) (
  input  logic clk,
  input  logic srst_n,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic pre_tick
);

  localparam int W = $clog2(ClkDiv);
  localparam logic [W-1:0] Last = W'(ClkDiv - 1);
  localparam logic [W-1:0] Pre  = W'(ClkDiv - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!srst_n || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + W'(1);
    end
  end

  // pre_tick lets the owner register a pulse that lands on the tick cycle
  assign tick     = (count == Last);
  assign pre_tick = (count == Pre);

endmodule

// File: rtl/fifo_uart9_tx.sv
// rtl/fifo_uart9_tx.sv - pops 9-bit words from a standard FIFO and sends them as start/9 data/stop frames
import fifo_uart9_pkg::*;

module fifo_uart9_tx #(
  parameter int ClkDiv   = 16,
  parameter int StopBits = 1
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     enable,
  input  logic [FrameDataBits-1:0] fifo_dout,
  input  logic                     fifo_valid,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     underrun
);

  state_t                   state, state_d;
  logic [FrameDataBits-1:0] shreg, shreg_d;
  logic [3:0]               bit_idx, bit_idx_d;
  logic                     stop_idx, stop_idx_d;
  logic                     tx_d, rd_en_d, done_d, under_d;
  logic                     tick, pre_tick;
  logic                     last_stop;

  uart_bit_timer #(.ClkDiv(ClkDiv)) u_timer (
    .clk      (clk),
    .srst_n   (srst_n),
    .clear    (state == S_FETCH),
    .run      ((state == S_START) || (state == S_DATA) || (state == S_STOP)),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign last_stop = (stop_idx == 1'(StopBits - 1));

  // tx_d is the line level for the cycle after this edge, so tx stays a pure flop
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    tx_d       = 1'b1;
    done_d     = 1'b0;
    under_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_rd_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fifo_valid) begin
          shreg_d = fifo_dout;
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          under_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = 4'd0;
          tx_d      = shreg[0];
        end
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (tick) begin
          if (bit_idx == LastBitIdx) begin
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            shreg_d   = shreg >> 1;
            bit_idx_d = bit_idx + 4'd1;
            tx_d      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (pre_tick && last_stop) done_d = 1'b1;
        if (tick) begin
          if (last_stop) state_d = S_IDLE;
          else           stop_idx_d = stop_idx + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop is issued on entry to IDLE, so back-to-back frames start right after the last stop cycle
  assign rd_en_d = (state_d == S_IDLE) && enable && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_idx    <= bit_idx_d;
      stop_idx   <= stop_idx_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= done_d;
      underrun   <= under_d;
    end
  end

endmodule
